control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 59 +++++
 rtl/cu_decode.sv | 90 +++++++++
 rtl/control_unit.sv | 94 +++++++++
 tb/tb_control_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state codes, ALU opcodes,
// datapath select encodings and the decoded control-word bundle.
package cu_pkg;

    typedef enum logic [3:0] {
        S_RST   = 4'd0,
        S_F0    = 4'd1,
        S_F1    = 4'd2,
        S_F2    = 4'd3,
        S_DEC   = 4'd4,
        S_DP    = 4'd5,
        S_ADDR  = 4'd6,
        S_LDRD  = 4'd7,
        S_LDWB  = 4'd8,
        S_STDAT = 4'd9,
        S_STWR  = 4'd10,
        S_BR    = 4'd11
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MOV = 4'b1101;

    localparam logic [1:0] MA_RN  = 2'd0;
    localparam logic [1:0] MA_RD  = 2'd1;
    localparam logic [1:0] MA_PC  = 2'd2;

    localparam logic [1:0] MB_REG = 2'd0;
    localparam logic [1:0] MB_SHF = 2'd1;
    localparam logic [1:0] MB_MDR = 2'd2;

    localparam logic       MC_RD  = 1'b0;
    localparam logic       MC_PC  = 1'b1;

    localparam logic [1:0] MJ_RM  = 2'd0;
    localparam logic [1:0] MJ_RD  = 2'd2;

    typedef struct packed {
        logic [1:0] ma;
        logic [1:0] mb;
        logic       mc;
        logic       md;
        logic       me;
        logic       mf;
        logic       mg;
        logic       mh;
        logic [1:0] mi;
        logic [1:0] mj;
        logic [3:0] op;
        logic       rf_ld;
        logic       ir_ld;
        logic       mar_ld;
        logic       mdr_ld;
        logic       flags_ld;
        logic       mem_en;
        logic       mem_rw;
    } cu_out_t;

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decode from the current state and ir.
// Ports: state, ir, moc in; ctl (full control word) out.
module cu_decode
    import cu_pkg::*;
(
    input  state_t      state,
    input  logic [31:0] ir,
    input  logic        moc,
    output cu_out_t     ctl
);

    // Fields of ir not consumed by the decode.
    logic unused_ir;
    assign unused_ir = ^{ir[31:26], ir[22:21], ir[19:0]};

    always_comb begin
        ctl = '0;
        unique case (state)
            S_F0: begin
                ctl.ma     = MA_PC;
                ctl.mf     = 1'b1;
                ctl.mar_ld = 1'b1;
            end
            S_F1: begin
                ctl.ma    = MA_PC;
                ctl.mb    = MB_SHF;
                ctl.md    = 1'b1;
                ctl.op    = OP_ADD;
                ctl.mc    = MC_PC;
                ctl.rf_ld = 1'b1;
            end
            S_F2: begin
                ctl.mem_en = 1'b1;
                ctl.mem_rw = 1'b1;
                // IR captures the fetched word on the completing cycle only.
                ctl.ir_ld  = moc;
            end
            S_DP: begin
                ctl.ma       = MA_RN;
                ctl.mb       = ir[25] ? MB_SHF : MB_REG;
                ctl.mj       = MJ_RM;
                ctl.mc       = MC_RD;
                // TST/TEQ/CMP/CMN only update flags.
                ctl.rf_ld    = (ir[24:23] != 2'b10);
                ctl.flags_ld = ir[20];
            end
            S_ADDR: begin
                ctl.ma     = MA_RN;
                ctl.mb     = MB_SHF;
                ctl.md     = 1'b1;
                ctl.op     = ir[23] ? OP_ADD : OP_SUB;
                ctl.mar_ld = 1'b1;
            end
            S_LDRD: begin
                ctl.mem_en = 1'b1;
                ctl.mem_rw = 1'b1;
                ctl.mdr_ld = moc;
            end
            S_LDWB: begin
                ctl.mb    = MB_MDR;
                ctl.md    = 1'b1;
                ctl.op    = OP_MOV;
                ctl.mc    = MC_RD;
                ctl.rf_ld = 1'b1;
            end
            S_STDAT: begin
                ctl.mj     = MJ_RD;
                ctl.mb     = MB_REG;
                ctl.md     = 1'b1;
                ctl.op     = OP_MOV;
                ctl.mg     = 1'b1;
                ctl.mdr_ld = 1'b1;
            end
            S_STWR: begin
                ctl.mem_en = 1'b1;
                ctl.mem_rw = 1'b0;
            end
            S_BR: begin
                ctl.ma    = MA_PC;
                ctl.mb    = MB_SHF;
                ctl.md    = 1'b1;
                ctl.op    = OP_ADD;
                ctl.mc    = MC_PC;
                ctl.rf_ld = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control unit: state register and next-state logic; the
// control word comes from cu_decode. Ports: clk, rst_n, ir, cond_ok, moc
// in; datapath selects MA..MJ, op, load strobes, mem_en/mem_rw, state out.
module control_unit
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cond_ok,
    input  logic        moc,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic        MC,
    output logic        MD,
    output logic        ME,
    output logic        MF,
    output logic        MG,
    output logic        MH,
    output logic [1:0]  MI,
    output logic [1:0]  MJ,
    output logic [3:0]  op,
    output logic        rf_ld,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        flags_ld,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [3:0]  state
);

    state_t  cur;
    state_t  nxt;
    cu_out_t ctl;

    always_comb begin
        nxt = S_RST;
        unique case (cur)
            S_RST:   nxt = S_F0;
            S_F0:    nxt = S_F1;
            S_F1:    nxt = S_F2;
            S_F2:    nxt = moc ? S_DEC : S_F2;
            S_DEC: begin
                if (!cond_ok)                 nxt = S_F0;
                else if (ir[27:26] == 2'b00)  nxt = S_DP;
                else if (ir[27:26] == 2'b01)  nxt = S_ADDR;
                else if (ir[27:25] == 3'b101) nxt = S_BR;
                else                          nxt = S_F0;
            end
            S_DP:    nxt = S_F0;
            S_ADDR:  nxt = ir[20] ? S_LDRD : S_STDAT;
            S_LDRD:  nxt = moc ? S_LDWB : S_LDRD;
            S_LDWB:  nxt = S_F0;
            S_STDAT: nxt = S_STWR;
            S_STWR:  nxt = moc ? S_F0 : S_STWR;
            S_BR:    nxt = S_F0;
            default: nxt = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cur <= S_RST;
        else        cur <= nxt;
    end

    cu_decode u_decode (
        .state (cur),
        .ir    (ir),
        .moc   (moc),
        .ctl   (ctl)
    );

    assign MA       = ctl.ma;
    assign MB       = ctl.mb;
    assign MC       = ctl.mc;
    assign MD       = ctl.md;
    assign ME       = ctl.me;
    assign MF       = ctl.mf;
    assign MG       = ctl.mg;
    assign MH       = ctl.mh;
    assign MI       = ctl.mi;
    assign MJ       = ctl.mj;
    assign op       = ctl.op;
    assign rf_ld    = ctl.rf_ld;
    assign ir_ld    = ctl.ir_ld;
    assign mar_ld   = ctl.mar_ld;
    assign mdr_ld   = ctl.mdr_ld;
    assign flags_ld = ctl.flags_ld;
    assign mem_en   = ctl.mem_en;
    assign mem_rw   = ctl.mem_rw;
    assign state    = cur;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: walks instructions through the FSM and checks
// every cycle's full control word against an instruction-level model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ir;
    logic        cond_ok;
    logic        moc;
    logic [1:0]  MA, MB, MI, MJ;
    logic        MC, MD, ME, MF, MG, MH;
    logic [3:0]  op;
    logic        rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld;
    logic        mem_en, mem_rw;
    logic [3:0]  state;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    localparam logic [6:0] RF   = 7'b1000000;
    localparam logic [6:0] IRL  = 7'b0100000;
    localparam logic [6:0] MARL = 7'b0010000;
    localparam logic [6:0] MDRL = 7'b0001000;
    localparam logic [6:0] FL   = 7'b0000100;
    localparam logic [6:0] EN   = 7'b0000010;
    localparam logic [6:0] RW   = 7'b0000001;
    localparam logic [6:0] NONE = 7'b0000000;

    localparam logic [3:0] ADD = 4'b0100;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] MOV = 4'b1101;

    control_unit dut (
        .clk(clk), .rst_n(rst_n), .ir(ir), .cond_ok(cond_ok), .moc(moc),
        .MA(MA), .MB(MB), .MC(MC), .MD(MD), .ME(ME), .MF(MF), .MG(MG),
        .MH(MH), .MI(MI), .MJ(MJ), .op(op), .rf_ld(rf_ld), .ir_ld(ir_ld),
        .mar_ld(mar_ld), .mdr_ld(mdr_ld), .flags_ld(flags_ld),
        .mem_en(mem_en), .mem_rw(mem_rw), .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word; ME, MH, MI are never asserted by any state.
    function automatic logic [28:0] ev(
        input logic [3:0] s, input logic [1:0] ma, input logic [1:0] mb,
        input logic mc, input logic md, input logic mf, input logic mg,
        input logic [1:0] mj, input logic [3:0] o, input logic [6:0] st);
        return {s, ma, mb, mc, md, 1'b0, mf, mg, 1'b0, 2'b00, mj, o, st};
    endfunction

    function automatic logic [28:0] obs();
        return {state, MA, MB, MC, MD, ME, MF, MG, MH, MI, MJ, op,
                rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw};
    endfunction

    // Check the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [28:0] exp);
        logic [28:0] got;
        #1;
        got = obs();
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // One instruction from S_F0 up to (not including) the next S_F0.
    task automatic run(input logic [31:0] i, input logic c,
                       input int wf, input int wm);
        logic [6:0] dp;
        ir = i;
        cond_ok = c;
        moc = 1'b0;
        cyc("f0", ev(1, 2, 0, 0, 0, 1, 0, 0, 0, MARL));
        cyc("f1", ev(2, 2, 1, 1, 1, 0, 0, 0, ADD, RF));
        repeat (wf) cyc("f2_wait", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, EN | RW));
        moc = 1'b1;
        cyc("f2_done", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, IRL | EN | RW));
        moc = 1'b0;
        cyc("dec", ev(4, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        if (!c) return;
        if (i[27:26] == 2'b00) begin
            dp = ((i[24:23] != 2'b10) ? RF : NONE) | (i[20] ? FL : NONE);
            cyc("dp", ev(5, 0, {1'b0, i[25]}, 0, 0, 0, 0, 0, 0, dp));
        end else if (i[27:26] == 2'b01) begin
            cyc("addr", ev(6, 0, 1, 0, 1, 0, 0, 0, i[23] ? ADD : SUB, MARL));
            if (i[20]) begin
                repeat (wm)
                    cyc("ld_wait", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, EN | RW));
                moc = 1'b1;
                cyc("ld_done", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, MDRL | EN | RW));
                moc = 1'b0;
                cyc("ldwb", ev(8, 0, 2, 0, 1, 0, 0, 0, MOV, RF));
            end else begin
                cyc("stdat", ev(9, 0, 0, 0, 1, 0, 1, 2, MOV, MDRL));
                repeat (wm)
                    cyc("st_wait", ev(10, 0, 0, 0, 0, 0, 0, 0, 0, EN));
                moc = 1'b1;
                cyc("st_done", ev(10, 0, 0, 0, 0, 0, 0, 0, 0, EN));
                moc = 1'b0;
            end
        end else if (i[27:25] == 3'b101) begin
            cyc("br", ev(11, 2, 1, 1, 1, 0, 0, 0, ADD, RF));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ir = '0;
        cond_ok = 1'b0;
        moc = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_hold", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        rst_n = 1'b1;
        cyc("rst_rel", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));

        run(32'hE0821003, 1'b1, 3, 0);
        run(32'hE1510002, 1'b1, 0, 0);
        run(32'hE5910004, 1'b1, 0, 2);
        run(32'hE5010004, 1'b1, 1, 1);
        run(32'h0A000002, 1'b0, 0, 0);
        run(32'h0A000002, 1'b1, 0, 0);
        run(32'hEC000000, 1'b1, 0, 0);

        for (int n = 0; n < 60; n++)
            run($urandom, ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset asserted in the middle of a load wait.
        ir = 32'hE5910004;
        cond_ok = 1'b1;
        moc = 1'b0;
        cyc("r_f0", ev(1, 2, 0, 0, 0, 1, 0, 0, 0, MARL));
        cyc("r_f1", ev(2, 2, 1, 1, 1, 0, 0, 0, ADD, RF));
        moc = 1'b1;
        cyc("r_f2", ev(3, 0, 0, 0, 0, 0, 0, 0, 0, IRL | EN | RW));
        moc = 1'b0;
        cyc("r_dec", ev(4, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        cyc("r_addr", ev(6, 0, 1, 0, 1, 0, 0, 0, ADD, MARL));
        cyc("r_ldw", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, EN | RW));
        rst_n = 1'b0;
        cyc("r_ldw_rst", ev(7, 0, 0, 0, 0, 0, 0, 0, 0, EN | RW));
        cyc("mid_rst1", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        rst_n = 1'b1;
        cyc("mid_rst2", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE));
        run(32'hE0821003, 1'b1, 0, 0);
        cyc("final_f0", ev(1, 2, 0, 0, 0, 1, 0, 0, 0, MARL));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
